ddr_local_responder: RTL and testbench

- Responder (slave) end of the DDR controller local interface: local_address, local_burstbegin, local_read_req, local_write_req, local_size, local_be, local_wdata_req, local_rdata, local_rdata_valid, local_init_done.
- Backs the interface with on-chip storage so the local-side initiator and its FIFOs can run without the PHY or DDR device.
- Reproduces init delay, write-data request timing and read latency on a single clock.

---
 rtl/ddr_local_responder.sv | 182 ++++++++++++++++++
 tb/tb_ddr_local_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_local_responder.sv
// rtl/ddr_local_responder.sv - DDR local-interface responder backed by on-chip storage
// Models init delay, write-data request timing and fixed read latency on one clock.
module ddr_local_responder #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 25,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int INIT_CYCLES    = 64,
  parameter int RD_LATENCY     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   local_address,
  input  logic                    local_burstbegin,
  input  logic                    local_read_req,
  input  logic                    local_write_req,
  input  logic [2:0]              local_size,
  input  logic [DATA_WIDTH/8-1:0] local_be,
  input  logic [DATA_WIDTH-1:0]   local_wdata,
  output logic                    local_ready,
  output logic                    local_wdata_req,
  output logic [DATA_WIDTH-1:0]   local_rdata,
  output logic                    local_rdata_valid,
  output logic                    local_init_done
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;
  localparam int IW    = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int LW    = $clog2(RD_LATENCY);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RDONE
  } state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           init_cnt_q, init_cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [2:0]              size_q, size_d;
  logic [BE_W-1:0]         be_q, be_d;
  logic [2:0]              req_cnt_q, req_cnt_d;
  logic [2:0]              beat_q, beat_d;
  logic [LW-1:0]           lat_q, lat_d;
  logic                    wreq_q, wreq_d;
  logic                    wpend_q, wpend_d;
  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    done_q, done_d;
  logic                    ready;

  logic [DATA_WIDTH-1:0]     mem [DEPTH];
  logic [MEM_DEPTH_LOG2-1:0] beat_idx;
  logic [DATA_WIDTH-1:0]     mem_rd;
  logic                      mem_we;

  // Modulo by the power-of-two depth gives the wrap-to-word-0 behaviour.
  assign beat_idx = MEM_DEPTH_LOG2'((addr_q + ADDR_WIDTH'(beat_q)) % DEPTH_A);
  assign mem_rd   = mem[beat_idx];
  assign mem_we   = (state_q == S_WRITE) && wpend_q;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    addr_d     = addr_q;
    size_d     = size_q;
    be_d       = be_q;
    req_cnt_d  = req_cnt_q;
    beat_d     = beat_q;
    lat_d      = lat_q;
    wreq_d     = wreq_q;
    wpend_d    = wpend_q;
    valid_d    = 1'b0;
    rdata_d    = rdata_q;
    done_d     = done_q;
    ready      = 1'b0;
    case (state_q)
      S_INIT: begin
        if (init_cnt_q == IW'(INIT_CYCLES - 1)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          init_cnt_d = init_cnt_q + IW'(1);
        end
      end
      S_IDLE: begin
        ready = 1'b1;
        if (local_burstbegin && (local_read_req || local_write_req)) begin
          addr_d = local_address;
          size_d = (local_size == 3'd0) ? 3'd1 : local_size;
          be_d   = local_be;
          beat_d = 3'd0;
          // A write wins over a simultaneous read; the read is simply dropped.
          if (local_write_req) begin
            state_d   = S_WRITE;
            wreq_d    = 1'b1;
            req_cnt_d = 3'd1;
            wpend_d   = 1'b0;
          end else begin
            state_d = S_READ;
            lat_d   = LW'(RD_LATENCY - 2);
          end
        end
      end
      S_WRITE: begin
        // wpend marks the cycle the initiator answers a wdata_req with data.
        wpend_d = wreq_q;
        if (wreq_q) begin
          if (req_cnt_q == size_q) wreq_d = 1'b0;
          else                     req_cnt_d = req_cnt_q + 3'd1;
        end
        if (wpend_q) begin
          beat_d = beat_q + 3'd1;
          if (beat_q == size_q - 3'd1) state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (lat_q != '0) begin
          lat_d = lat_q - LW'(1);
        end else begin
          valid_d = 1'b1;
          rdata_d = mem_rd;
          beat_d  = beat_q + 3'd1;
          if (beat_q == size_q - 3'd1) state_d = S_RDONE;
        end
      end
      S_RDONE: state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      addr_q     <= '0;
      size_q     <= 3'd0;
      be_q       <= '0;
      req_cnt_q  <= 3'd0;
      beat_q     <= 3'd0;
      lat_q      <= '0;
      wreq_q     <= 1'b0;
      wpend_q    <= 1'b0;
      valid_q    <= 1'b0;
      rdata_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      be_q       <= be_d;
      req_cnt_q  <= req_cnt_d;
      beat_q     <= beat_d;
      lat_q      <= lat_d;
      wreq_q     <= wreq_d;
      wpend_q    <= wpend_d;
      valid_q    <= valid_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
    end
  end

  // Storage is deliberately unreset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_q[b]) mem[beat_idx][b*8 +: 8] <= local_wdata[b*8 +: 8];
      end
    end
  end

  assign local_ready       = ready;
  assign local_wdata_req   = wreq_q;
  assign local_rdata       = rdata_q;
  assign local_rdata_valid = valid_q;
  assign local_init_done   = done_q;

endmodule

// File: tb/tb_ddr_local_responder.sv
// tb/tb_ddr_local_responder.sv - directed self-checking bench for ddr_local_responder
// Inputs driven and outputs sampled on the falling edge.
module tb_ddr_local_responder;

  localparam int RL = 4;

  logic        clk;
  logic        reset;
  logic [24:0] local_address;
  logic        local_burstbegin;
  logic        local_read_req;
  logic        local_write_req;
  logic [2:0]  local_size;
  logic [3:0]  local_be;
  logic [31:0] local_wdata;
  logic        local_ready;
  logic        local_wdata_req;
  logic [31:0] local_rdata;
  logic        local_rdata_valid;
  logic        local_init_done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] wd [8];
  logic [31:0] ed [8];

  ddr_local_responder #(
    .DATA_WIDTH(32), .ADDR_WIDTH(25), .MEM_DEPTH_LOG2(10), .INIT_CYCLES(64), .RD_LATENCY(RL)
  ) dut (
    .clk(clk), .reset(reset), .local_address(local_address),
    .local_burstbegin(local_burstbegin), .local_read_req(local_read_req),
    .local_write_req(local_write_req), .local_size(local_size), .local_be(local_be),
    .local_wdata(local_wdata), .local_ready(local_ready), .local_wdata_req(local_wdata_req),
    .local_rdata(local_rdata), .local_rdata_valid(local_rdata_valid),
    .local_init_done(local_init_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, local_ready, 0);
    chk({tag, "_wreq"}, local_wdata_req, 0);
    chk({tag, "_valid"}, local_rdata_valid, 0);
    chk({tag, "_rdata"}, local_rdata, 0);
    chk({tag, "_done"}, local_init_done, 0);
  endtask

  task automatic do_write(input logic [24:0] a, input logic [2:0] raw, input int n,
                          input logic [3:0] be, input logic both);
    logic [15:0] reqmask;
    logic        prev_req;
    logic        saw_valid;
    int          k;
    chk("wr_ready_pre", local_ready, 1);
    local_address = a; local_size = raw; local_be = be;
    local_burstbegin = 1'b1; local_write_req = 1'b1; local_read_req = both;
    reqmask = '0; prev_req = 1'b0; saw_valid = 1'b0; k = 0;
    for (int j = 0; j <= n + 1; j++) begin
      @(negedge clk);
      if (j == 0) begin
        local_burstbegin = 1'b0; local_write_req = 1'b0; local_read_req = 1'b0;
        chk("wr_ready_drop", local_ready, 0);
      end
      if (local_wdata_req) reqmask[j] = 1'b1;
      if (local_rdata_valid) saw_valid = 1'b1;
      if (j == n) chk("wr_ready_low", local_ready, 0);
      if (prev_req && k < 8) begin
        local_wdata = wd[k];
        k++;
      end
      prev_req = local_wdata_req;
    end
    chk("wr_req_mask", reqmask, (64'd1 << n) - 64'd1);
    chk("wr_ready_back", local_ready, 1);
    if (both) chk("both_no_valid", saw_valid, 0);
  endtask

  task automatic do_read(input logic [24:0] a, input logic [2:0] raw, input int n);
    logic [31:0] vmask;
    int          k;
    chk("rd_ready_pre", local_ready, 1);
    local_address = a; local_size = raw;
    local_burstbegin = 1'b1; local_read_req = 1'b1;
    vmask = '0; k = 0;
    for (int j = 0; j < RL + n; j++) begin
      @(negedge clk);
      if (j == 0) begin
        local_burstbegin = 1'b0; local_read_req = 1'b0;
      end
      if (local_rdata_valid) begin
        vmask[j] = 1'b1;
        if (k < 8) chk("rd_data", local_rdata, ed[k]);
        k++;
      end
      if (j == RL + n - 2) chk("rd_ready_low", local_ready, 0);
    end
    chk("rd_valid_mask", vmask, ((64'd1 << n) - 64'd1) << (RL - 1));
    chk("rd_ready_back", local_ready, 1);
  endtask

  initial begin
    logic seen;
    int   done_at;
    reset = 1'b0;
    local_address = '0; local_burstbegin = 1'b0; local_read_req = 1'b0;
    local_write_req = 1'b0; local_size = 3'd0; local_be = 4'h0; local_wdata = '0;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");

    // Init delay; a write pulse during init must be ignored.
    reset = 1'b1;
    seen = 1'b0;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if (local_wdata_req) seen = 1'b1;
      if (c == 9) begin local_burstbegin = 1'b1; local_write_req = 1'b1; local_size = 3'd2; end
      if (c == 10) begin local_burstbegin = 1'b0; local_write_req = 1'b0; end
      if (c == 63) begin
        chk("init_done_c63", local_init_done, 0);
        chk("init_ready_c63", local_ready, 0);
      end
      if (c == 64) begin
        chk("init_done_c64", local_init_done, 1);
        chk("init_ready_c64", local_ready, 1);
      end
    end
    chk("init_no_wreq", seen, 0);

    // Four-beat write then read back.
    wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33333333; wd[3] = 32'h44444444;
    do_write(25'h10, 3'd4, 4, 4'hF, 1'b0);
    ed[0] = 32'h11111111; ed[1] = 32'h22222222; ed[2] = 32'h33333333; ed[3] = 32'h44444444;
    do_read(25'h10, 3'd4, 4);
    chk("rdata_hold", local_rdata, 32'h44444444);

    // Byte-enable merge.
    wd[0] = 32'hFFFFFFFF;
    do_write(25'h5, 3'd1, 1, 4'hF, 1'b0);
    wd[0] = 32'h00000000;
    do_write(25'h5, 3'd1, 1, 4'h5, 1'b0);
    ed[0] = 32'hFF00FF00;
    do_read(25'h5, 3'd1, 1);

    // Wrap across the top of storage.
    wd[0] = 32'hAAAA0001; wd[1] = 32'hBBBB0002; wd[2] = 32'hCCCC0003;
    do_write(25'd1022, 3'd3, 3, 4'hF, 1'b0);
    ed[0] = 32'hCCCC0003; do_read(25'd0, 3'd1, 1);
    ed[0] = 32'hAAAA0001; do_read(25'd1022, 3'd1, 1);
    ed[0] = 32'hBBBB0002; do_read(25'd1023, 3'd1, 1);
    ed[0] = 32'hAAAA0001; ed[1] = 32'hBBBB0002; ed[2] = 32'hCCCC0003;
    do_read(25'd1022, 3'd3, 3);

    // Size 0 behaves as a single beat.
    wd[0] = 32'h0D0D0D0D;
    do_write(25'h7, 3'd0, 1, 4'hF, 1'b0);
    ed[0] = 32'h0D0D0D0D;
    do_read(25'h7, 3'd0, 1);

    // Simultaneous read and write: write executes, read dropped.
    wd[0] = 32'hDEAD0001; wd[1] = 32'hDEAD0002;
    do_write(25'h20, 3'd2, 2, 4'hF, 1'b1);
    seen = 1'b0;
    repeat (RL + 2) begin
      @(negedge clk);
      if (local_rdata_valid) seen = 1'b1;
    end
    chk("both_dropped_read", seen, 0);
    ed[0] = 32'hDEAD0001; ed[1] = 32'hDEAD0002;
    do_read(25'h20, 3'd2, 2);

    // Requests without burstbegin are ignored.
    local_read_req = 1'b1; local_write_req = 1'b1; local_size = 3'd2;
    @(negedge clk);
    local_read_req = 1'b0; local_write_req = 1'b0;
    seen = 1'b0;
    repeat (RL + 2) begin
      @(negedge clk);
      if (local_rdata_valid || local_wdata_req || !local_ready) seen = 1'b1;
    end
    chk("no_burstbegin_ignored", seen, 0);

    // Reset during the second beat of a four-beat read.
    local_address = 25'h10; local_size = 3'd4; local_burstbegin = 1'b1; local_read_req = 1'b1;
    @(negedge clk);
    local_burstbegin = 1'b0; local_read_req = 1'b0;
    for (int j = 1; j <= RL; j++) begin
      @(negedge clk);
      if (j == RL - 1) chk("abort_beat0", local_rdata, 32'h11111111);
      if (j == RL) begin
        chk("abort_beat1_valid", local_rdata_valid, 1);
        chk("abort_beat1", local_rdata, 32'h22222222);
      end
    end
    reset = 1'b0;
    #1;
    chk_all_zero("abort");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    done_at = 0;
    for (int c = 1; c <= 200 && done_at == 0; c++) begin
      @(negedge clk);
      if (local_rdata_valid) seen = 1'b1;
      if (local_init_done) done_at = c;
    end
    chk("reinit_cycles", done_at, 64);
    repeat (10) begin
      @(negedge clk);
      if (local_rdata_valid) seen = 1'b1;
    end
    chk("no_stale_valid", seen, 0);
    chk("rdata_zero_after_reset", local_rdata, 0);
    ed[0] = 32'h11111111;
    do_read(25'h10, 3'd1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
